// File: rtl/freq_analyzer_pkg.sv
// Shared state encoding, register-port opcodes and arithmetic helpers
// for the multi-pixel frequency analyzer.
package freq_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0]  REG_OP_NONE  = 2'd0;
  localparam logic [1:0]  REG_OP_WRITE = 2'd2;
  localparam logic [31:0] SAT_MAX      = 32'hFFFF_FFFF;

  // Period in clocks of a tone at (f + dev) Hz; pass a negative dev for the long limit.
  function automatic logic [31:0] period_limit(input longint clk, input longint f, input longint dev);
    longint hz;
    hz = f + dev;
    if (hz <= 0) return SAT_MAX;
    return 32'(clk / hz);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? SAT_MAX : sum[31:0];
  endfunction

endpackage

// File: rtl/pixel_period_classifier.sv
// One monitored pixel: binarises it, times the gaps between rising edges
// and accumulates that time into band 0, band 1 or unknown.
module pixel_period_classifier
  import freq_analyzer_pkg::*;
#(
  parameter logic [7:0]  THRESHOLD = 8'hC0,
  parameter logic [31:0] PMIN0     = 32'd0,
  parameter logic [31:0] PMAX0     = 32'd0,
  parameter logic [31:0] PMIN1     = 32'd0,
  parameter logic [31:0] PMAX1     = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_hit_i,
  input  logic [7:0]  data_i,
  input  logic        run_i,
  input  logic        clr_i,
  output logic [31:0] f0_o,
  output logic [31:0] f1_o,
  output logic [31:0] unk_o
);

  logic        sample_q, sample_d;
  logic        sample_dly_q;
  logic        armed_q, armed_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] f0_q, f0_d;
  logic [31:0] f1_q, f1_d;
  logic [31:0] unk_q, unk_d;
  logic        rise;
  logic        in_band0;
  logic        in_band1;

  assign rise     = sample_q & ~sample_dly_q;
  assign in_band0 = (period_cnt_q >= PMIN0) && (period_cnt_q <= PMAX0);
  assign in_band1 = (period_cnt_q >= PMIN1) && (period_cnt_q <= PMAX1);

  always_comb begin
    sample_d     = pixel_hit_i ? (data_i >= THRESHOLD) : sample_q;
    armed_d      = armed_q;
    period_cnt_d = period_cnt_q;
    f0_d         = f0_q;
    f1_d         = f1_q;
    unk_d        = unk_q;
    if (clr_i) begin
      armed_d      = 1'b0;
      period_cnt_d = '0;
      f0_d         = '0;
      f1_d         = '0;
      unk_d        = '0;
    end else if (run_i) begin
      if (rise) begin
        // The arming edge only opens the first period.
        if (armed_q) begin
          if (in_band0)      f0_d  = sat_add(f0_q, period_cnt_q);
          else if (in_band1) f1_d  = sat_add(f1_q, period_cnt_q);
          else               unk_d = sat_add(unk_q, period_cnt_q);
        end
        armed_d      = 1'b1;
        period_cnt_d = 32'd1;
      end else if (period_cnt_q != SAT_MAX) begin
        period_cnt_d = period_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sample_q     <= 1'b0;
      sample_dly_q <= 1'b0;
      armed_q      <= 1'b0;
      period_cnt_q <= '0;
      f0_q         <= '0;
      f1_q         <= '0;
      unk_q        <= '0;
    end else begin
      sample_q     <= sample_d;
      sample_dly_q <= sample_q;
      armed_q      <= armed_d;
      period_cnt_q <= period_cnt_d;
      f0_q         <= f0_d;
      f1_q         <= f1_d;
      unk_q        <= unk_d;
    end
  end

  assign f0_o  = f0_q;
  assign f1_o  = f1_q;
  assign unk_o = unk_q;

endmodule

// File: rtl/multi_pixel_frequency_analyzer.sv
// N-channel pixel frequency analyzer: per-channel period classifiers plus a
// sequencer that dumps every accumulator over the register port on stop.
//
// state    | meaning
// ST_IDLE  | waiting for start, outputs quiet
// ST_RUN   | channels timing edges and accumulating
// ST_WRITE | accumulators frozen, register writes in progress
// ST_DONE  | write-out complete, irq held
module multi_pixel_frequency_analyzer
  import freq_analyzer_pkg::*;
#(
  parameter int                                CHANNELS            = 3,
  parameter int                                PIXEL_INDEX_W       = 16,
  parameter logic [CHANNELS*PIXEL_INDEX_W-1:0] PIXEL_INDICES       = {16'd1023, 16'd511, 16'd63},
  parameter logic [CHANNELS*32-1:0]            FREQ0_HZ            = {32'd25000, 32'd15000, 32'd5000},
  parameter logic [CHANNELS*32-1:0]            FREQ1_HZ            = {32'd30000, 32'd20000, 32'd10000},
  parameter int                                FREQUENCY_DEVIATION = 20,
  parameter int                                CLOCK_FREQUENCY     = 100000000,
  parameter logic [7:0]                        THRESHOLD           = 8'hC0,
  parameter int                                HOLD_CYCLES         = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        line_start,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [1:0]  register_operation,
  output logic [7:0]  register_number,
  output logic [31:0] register_write,
  output logic        busy,
  output logic        irq
);

  localparam int                NUM_REGS  = 3 * CHANNELS;
  localparam int                CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]        LAST_IDX  = 8'(NUM_REGS);

  state_e                   state_q, state_d;
  logic [PIXEL_INDEX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIXEL_INDEX_W-1:0] pix_idx;
  logic [7:0]               idx_q, idx_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [1:0]               sel_q, sel_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     acc_clr;
  logic                     run;
  logic [CHANNELS-1:0]      pixel_hit;
  logic [31:0]              f0_w  [CHANNELS];
  logic [31:0]              f1_w  [CHANNELS];
  logic [31:0]              unk_w [CHANNELS];
  logic [31:0]              value_mux;

  // line_start renumbers the pixel presented in the same cycle as index 0.
  assign pix_idx   = line_start ? '0 : pix_cnt_q;
  assign pix_cnt_d = data_valid ? pix_idx + PIXEL_INDEX_W'(1) : pix_cnt_q;
  assign run       = (state_q == ST_RUN);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    localparam logic [31:0] F0    = FREQ0_HZ[ch*32 +: 32];
    localparam logic [31:0] F1    = FREQ1_HZ[ch*32 +: 32];
    localparam logic [31:0] PMIN0 = period_limit(longint'(CLOCK_FREQUENCY), longint'(F0),
                                                 longint'(FREQUENCY_DEVIATION));
    localparam logic [31:0] PMAX0 = period_limit(longint'(CLOCK_FREQUENCY), longint'(F0),
                                                 -longint'(FREQUENCY_DEVIATION));
    localparam logic [31:0] PMIN1 = period_limit(longint'(CLOCK_FREQUENCY), longint'(F1),
                                                 longint'(FREQUENCY_DEVIATION));
    localparam logic [31:0] PMAX1 = period_limit(longint'(CLOCK_FREQUENCY), longint'(F1),
                                                 -longint'(FREQUENCY_DEVIATION));

    assign pixel_hit[ch] = data_valid &&
                           (pix_idx == PIXEL_INDICES[ch*PIXEL_INDEX_W +: PIXEL_INDEX_W]);

    pixel_period_classifier #(
      .THRESHOLD (THRESHOLD),
      .PMIN0     (PMIN0),
      .PMAX0     (PMAX0),
      .PMIN1     (PMIN1),
      .PMAX1     (PMAX1)
    ) u_cls (
      .clock       (clock),
      .reset       (reset),
      .pixel_hit_i (pixel_hit[ch]),
      .data_i      (data),
      .run_i       (run),
      .clr_i       (acc_clr),
      .f0_o        (f0_w[ch]),
      .f1_o        (f1_w[ch]),
      .unk_o       (unk_w[ch])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          acc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // start beats a coincident stop: a restart, not a write-out.
        if (clear) begin
          state_d = ST_IDLE;
        end else if (start) begin
          acc_clr = 1'b1;
        end else if (stop) begin
          state_d = ST_WRITE;
          idx_d   = 8'd1;
          ch_d    = '0;
          sel_d   = 2'd0;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_WRITE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d  = idx_q + 8'd1;
          hold_d = HOLD_LOAD;
          if (sel_q == 2'd2) begin
            sel_d = 2'd0;
            ch_d  = ch_q + CH_W'(1);
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          acc_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    value_mux = f0_w[ch_q];
      2'd1:    value_mux = f1_w[ch_q];
      default: value_mux = unk_w[ch_q];
    endcase
    register_operation = REG_OP_NONE;
    register_number    = 8'd0;
    register_write     = 32'd0;
    if (state_q == ST_WRITE) begin
      register_operation = REG_OP_WRITE;
      register_number    = idx_q;
      register_write     = value_mux;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign irq  = (state_q == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      idx_q     <= '0;
      ch_q      <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_multi_pixel_frequency_analyzer.sv
// Directed bench for multi_pixel_frequency_analyzer at a 1 MHz nominal clock:
// ch0 band 0 = 199..200 clocks, band 1 = 99..100; ch1 (pixel 31) bands 66 and 49..50.
module tb_multi_pixel_frequency_analyzer;

  localparam int NUM_REGS = 9;
  localparam int HOLD     = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        data_valid = 1'b0;
  logic        line_start = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  register_operation;
  logic [7:0]  register_number;
  logic [31:0] register_write;
  logic        busy;
  logic        irq;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_regs [NUM_REGS];

  always #5 clock = ~clock;

  multi_pixel_frequency_analyzer #(
    .CHANNELS            (3),
    .PIXEL_INDEX_W       (16),
    .PIXEL_INDICES       ({16'd1023, 16'd31, 16'd63}),
    .FREQ0_HZ            ({32'd25000, 32'd15000, 32'd5000}),
    .FREQ1_HZ            ({32'd30000, 32'd20000, 32'd10000}),
    .FREQUENCY_DEVIATION (20),
    .CLOCK_FREQUENCY     (1_000_000),
    .THRESHOLD           (8'hC0),
    .HOLD_CYCLES         (HOLD)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .data               (data),
    .data_valid         (data_valid),
    .line_start         (line_start),
    .start              (start),
    .stop               (stop),
    .clear              (clear),
    .register_operation (register_operation),
    .register_number    (register_number),
    .register_write     (register_write),
    .busy               (busy),
    .irq                (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One video line; pixel hi_pix carries exactly THRESHOLD, all others sit one below it.
  task automatic send_line(input int len, input int hi_pix);
    for (int p = 0; p < len; p++) begin
      data_valid = 1'b1;
      line_start = (p == 0);
      data       = (p == hi_pix) ? 8'hC0 : 8'hBF;
      tick();
    end
    data_valid = 1'b0;
    line_start = 1'b0;
    data       = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_out(input string name);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int h = 0; h < HOLD; h++) begin
        check($sformatf("%s op r%0d h%0d", name, r + 1, h), 32'(register_operation), 32'd2);
        check($sformatf("%s num r%0d h%0d", name, r + 1, h), 32'(register_number), 32'(r + 1));
        check($sformatf("%s val r%0d h%0d", name, r + 1, h), register_write, exp_regs[r]);
        check($sformatf("%s irq low r%0d h%0d", name, r + 1, h), 32'(irq), 32'd0);
        tick();
      end
    end
    check({name, " irq at stop+37"}, 32'(irq), 32'd1);
    check({name, " op in done"}, 32'(register_operation), 32'd0);
    check({name, " num in done"}, 32'(register_number), 32'd0);
    check({name, " val in done"}, register_write, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check({name, " irq after clear"}, 32'(irq), 32'd0);
    check({name, " busy after clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   guard;
    logic irq_seen;

    @(negedge clock);
    repeat (3) tick();
    reset = 1'b0;
    check("reset op", 32'(register_operation), 32'd0);
    check("reset num", 32'(register_number), 32'd0);
    check("reset val", register_write, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset irq", 32'(irq), 32'd0);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop in idle busy", 32'(busy), 32'd0);
    check("stop in idle op", 32'(register_operation), 32'd0);

    // Five ch0 edges 200 clocks apart: four band-0 periods.
    pulse_start();
    check("run busy", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      send_line(100, 63);
      send_line(100, -1);
    end
    exp_regs = '{32'd800, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    write_out("f0");

    // Three ch1 edges 150 clocks apart: outside both ch1 bands.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      send_line(75, 31);
      send_line(75, -1);
    end
    exp_regs = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd300, 32'd0, 32'd0, 32'd0};
    write_out("unk");

    // start+stop together restarts; the next edge only re-arms.
    pulse_start();
    send_line(100, 63);
    send_line(100, -1);
    send_line(100, 63);
    send_line(100, -1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start+stop busy", 32'(busy), 32'd1);
    check("start+stop op", 32'(register_operation), 32'd0);
    check("start+stop irq", 32'(irq), 32'd0);
    send_line(100, 63);
    send_line(100, -1);
    exp_regs = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    write_out("restart");

    // Reset in the middle of the write-out.
    pulse_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    guard = 0;
    while (register_number != 8'd4 && guard < 60) begin
      tick();
      guard++;
    end
    check("reached idx 4", 32'(register_number), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset mid-write op", 32'(register_operation), 32'd0);
    check("reset mid-write num", 32'(register_number), 32'd0);
    check("reset mid-write busy", 32'(busy), 32'd0);
    irq_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (irq) irq_seen = 1'b1;
    end
    check("no irq after reset", 32'(irq_seen), 32'd0);

    // Saturation of the f0 accumulator and of the period counter.
    pulse_start();
    force dut.g_ch[0].u_cls.f0_q = 32'hFFFF_FFF6;
    tick();
    release dut.g_ch[0].u_cls.f0_q;
    send_line(100, 63);
    send_line(100, -1);
    send_line(100, 63);
    send_line(100, -1);
    force dut.g_ch[0].u_cls.period_cnt_q = 32'hFFFF_FFFD;
    tick();
    release dut.g_ch[0].u_cls.period_cnt_q;
    repeat (3) tick();
    check("period_cnt saturates", dut.g_ch[0].u_cls.period_cnt_q, 32'hFFFF_FFFF);
    send_line(100, 63);
    send_line(100, -1);
    exp_regs = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    write_out("sat");

    // Pixel index boundary and mid-line restart.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 70; p++) begin
      data_valid = 1'b1;
      line_start = (p == 0);
      data       = (p == 62 || p == 64) ? 8'hFF : 8'h00;
      tick();
    end
    data_valid = 1'b0;
    line_start = 1'b0;
    data       = 8'h00;
    tick();
    check("pixels 62/64 ignored", 32'(dut.g_ch[0].u_cls.sample_q), 32'd0);
    for (int p = 0; p < 30; p++) begin
      data_valid = 1'b1;
      line_start = (p == 0);
      data       = 8'h00;
      tick();
    end
    for (int q = 0; q < 70; q++) begin
      data_valid = 1'b1;
      line_start = (q == 0);
      data       = (q == 63) ? 8'hFF : 8'h00;
      tick();
    end
    data_valid = 1'b0;
    line_start = 1'b0;
    data       = 8'h00;
    tick();
    check("pixel 63 after line_start", 32'(dut.g_ch[0].u_cls.sample_q), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
